// File: rtl/data_memory_ctrl.sv
// Word-organised data memory with a fixed-latency request/response handshake.
// One transaction in flight: IDLE accepts, WAIT counts down, RESP strobes ready for one cycle.
module data_memory_ctrl #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_require,
    input  logic        memory_write_enable,
    input  logic [3:0]  memory_bytes_enable_map,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_write_data,
    output logic [31:0] memory_read_data,
    output logic        memory_ready,
    output logic        memory_error
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic [3:0]    cnt_r;
    logic [3:0]    cnt_next_s;
    logic          accept_s;
    logic          enter_resp_s;

    logic          we_r;
    logic [3:0]    be_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;

    logic          req_we_s;
    logic [3:0]    req_be_s;
    logic [31:0]   req_addr_s;
    logic [31:0]   req_wdata_s;
    logic [31:0]   word_off_s;
    logic          in_range_s;
    logic [AW-1:0] index_s;
    logic          commit_s;

    logic [31:0]   read_data_r;
    logic          ready_r;
    logic          error_r;

    logic [31:0]   mem_r [DEPTH_WORDS];

    // Next-state and down-counter logic
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (memory_require) begin
                    accept_s = 1'b1;
                    if (LATENCY == 1) begin
                        next_state_s = RESP;
                    end else begin
                        next_state_s = WAIT;
                        cnt_next_s   = CNT_LOAD;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = RESP;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // With LATENCY=1 the response is scheduled straight from IDLE, so the live inputs describe it
    always_comb begin
        req_we_s    = we_r;
        req_be_s    = be_r;
        req_addr_s  = addr_r;
        req_wdata_s = wdata_r;
        if (state_r == IDLE) begin
            req_we_s    = memory_write_enable;
            req_be_s    = memory_bytes_enable_map;
            req_addr_s  = memory_address;
            req_wdata_s = memory_write_data;
        end else begin
            req_we_s    = we_r;
            req_be_s    = be_r;
            req_addr_s  = addr_r;
            req_wdata_s = wdata_r;
        end
    end

    // Address decode and range check; the subtraction wraps when below base, caught by the compare
    always_comb begin
        word_off_s   = (req_addr_s - BASE_ADDR) >> 2;
        in_range_s   = (req_addr_s >= BASE_ADDR) && (word_off_s < 32'(DEPTH_WORDS));
        index_s      = word_off_s[AW-1:0];
        enter_resp_s = (next_state_s == RESP) && (state_r != RESP);
        commit_s     = enter_resp_s && req_we_s && in_range_s;
    end

    // Control state, request capture and registered response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            we_r        <= 1'b0;
            be_r        <= 4'd0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            ready_r     <= 1'b0;
            error_r     <= 1'b0;
            read_data_r <= 32'd0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
            if (accept_s) begin
                we_r    <= memory_write_enable;
                be_r    <= memory_bytes_enable_map;
                addr_r  <= memory_address;
                wdata_r <= memory_write_data;
            end
            ready_r <= enter_resp_s;
            if (enter_resp_s && !in_range_s) begin
                error_r     <= 1'b1;
                read_data_r <= 32'd0;
            end else if (enter_resp_s && !req_we_s) begin
                error_r     <= 1'b0;
                read_data_r <= mem_r[index_s];
            end else begin
                error_r     <= 1'b0;
                read_data_r <= read_data_r;
            end
        end
    end

    // Array write port; contents survive reset, but a write still pending under reset is dropped
    always_ff @(posedge clk) begin
        if (!reset && commit_s) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be_s[i]) begin
                    mem_r[index_s][8*i +: 8] <= req_wdata_s[8*i +: 8];
                end
            end
        end
    end

    assign memory_read_data = read_data_r;
    assign memory_ready     = ready_r;
    assign memory_error     = error_r;

endmodule
